// File: rtl/regfile_mp_pkg.sv
// Shared defaults, address-width helper and register typedefs for the register file.
package regfile_mp_pkg;

    localparam int unsigned DEF_WIDTH    = 32;
    localparam int unsigned DEF_NUM_REGS = 32;
    localparam int unsigned DEF_NUM_RD   = 2;
    localparam int unsigned DEF_NUM_WR   = 1;
    localparam bit          DEF_BYPASS   = 1'b1;

    // Address width for n registers; never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [DEF_WIDTH-1:0]              reg_data_t;
    typedef logic [addr_w(DEF_NUM_REGS)-1:0]   reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bundle of the register file: read ports, write ports, reservation.
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter int unsigned NUM_WR   = DEF_NUM_WR
);

    localparam int unsigned AW = addr_w(NUM_REGS);

    logic [NUM_RD-1:0][AW-1:0]    rd_addr;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_pending;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR-1:0][AW-1:0]    wr_addr;
    logic [NUM_WR-1:0][WIDTH-1:0] wr_data;
    logic                         rsv_en;
    logic [AW-1:0]                rsv_addr;

    // Pipeline side: issues addresses, writes and reservations.
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_pending
    );

    // Register file side.
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_pending
    );

endinterface

// File: rtl/regfile_mp_rd_port.sv
// One combinational read port: masks x0/out-of-range addresses and forwards same-cycle writes.
module regfile_mp_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned NUM_WR   = DEF_NUM_WR,
    parameter bit          BYPASS   = DEF_BYPASS,
    parameter int unsigned AW       = addr_w(NUM_REGS)
) (
    input  logic [AW-1:0]                rd_addr,
    input  logic [WIDTH-1:0]             arr_data,
    input  logic                         arr_pend,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
    input  logic [NUM_WR-1:0][WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_pending
);

    logic             rd_ok;
    logic             hit;
    logic [WIDTH-1:0] byp_data;

    assign rd_ok = (rd_addr != AW'(REG_ZERO)) && (32'(rd_addr) < NUM_REGS);

    // Scan write ports in ascending order so the highest-index hitting port is forwarded.
    always_comb begin
        hit      = 1'b0;
        byp_data = '0;
        for (int j = 0; j < int'(NUM_WR); j++) begin
            if (wr_en[j] && (wr_addr[j] == rd_addr)) begin
                hit      = 1'b1;
                byp_data = wr_data[j];
            end
        end
    end

    // Select between masked zero, forwarded write data and the stored value.
    always_comb begin
        rd_data    = '0;
        rd_pending = 1'b0;
        if (rd_ok) begin
            if (BYPASS && hit) begin
                // Forwarded data comes from the producer, so it is no longer outstanding.
                rd_data    = byp_data;
                rd_pending = 1'b0;
            end else begin
                rd_data    = arr_data;
                rd_pending = arr_pend;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file with optional write bypass and per-register pending bits.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter int unsigned NUM_WR   = DEF_NUM_WR,
    parameter bit          BYPASS   = DEF_BYPASS
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);

    localparam int unsigned AW = addr_w(NUM_REGS);

    logic [WIDTH-1:0]             regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]          pend_q;
    logic [NUM_RD-1:0][WIDTH-1:0] arr_data;
    logic [NUM_RD-1:0]            arr_pend;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_pending;

    // x0 and addresses past the last register are never stored or reserved.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != AW'(REG_ZERO)) && (32'(a) < NUM_REGS);
    endfunction

    // Storage and scoreboard update; ascending write loop lets the highest port win,
    // and the reservation comes last so a new producer outranks a completing one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (bus.wr_en[j] && addr_ok(bus.wr_addr[j])) begin
                    regs_q[bus.wr_addr[j]] <= bus.wr_data[j];
                    pend_q[bus.wr_addr[j]] <= 1'b0;
                end
            end
            if (bus.rsv_en && addr_ok(bus.rsv_addr)) begin
                pend_q[bus.rsv_addr] <= 1'b1;
            end
        end
    end

    // Raw array lookup per read port, guarded so unmapped addresses never index the array.
    always_comb begin
        arr_data = '0;
        arr_pend = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            if (addr_ok(bus.rd_addr[i])) begin
                arr_data[i] = regs_q[bus.rd_addr[i]];
                arr_pend[i] = pend_q[bus.rd_addr[i]];
            end
        end
    end

    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
        regfile_mp_rd_port #(
            .WIDTH    (WIDTH),
            .NUM_REGS (NUM_REGS),
            .NUM_WR   (NUM_WR),
            .BYPASS   (BYPASS),
            .AW       (AW)
        ) u_rd_port (
            .rd_addr    (bus.rd_addr[i]),
            .arr_data   (arr_data[i]),
            .arr_pend   (arr_pend[i]),
            .wr_en      (bus.wr_en),
            .wr_addr    (bus.wr_addr),
            .wr_data    (bus.wr_data),
            .rd_data    (rd_data[i]),
            .rd_pending (rd_pending[i])
        );
    end

    assign bus.rd_data    = rd_data;
    assign bus.rd_pending = rd_pending;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for two register file configurations sharing one stimulus stream:
// A = 24 regs, 2 write ports, bypass on; B = 32 regs, 1 write port, bypass off.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][4:0]  s_rd = '0;
    logic [1:0]       s_we = '0;
    logic [1:0][4:0]  s_wa = '0;
    logic [1:0][31:0] s_wd = '0;
    logic             s_rsv = 1'b0;
    logic [4:0]       s_ra = '0;
    bit               chk_en = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    regfile_mp_if #(.WIDTH(32), .NUM_REGS(24), .NUM_RD(2), .NUM_WR(2)) bus_a ();
    regfile_mp_if #(.WIDTH(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1)) bus_b ();

    assign bus_a.rd_addr  = s_rd;
    assign bus_a.wr_en    = s_we;
    assign bus_a.wr_addr  = s_wa;
    assign bus_a.wr_data  = s_wd;
    assign bus_a.rsv_en   = s_rsv;
    assign bus_a.rsv_addr = s_ra;
    assign bus_b.rd_addr  = s_rd;
    assign bus_b.wr_en    = s_we[0];
    assign bus_b.wr_addr  = s_wa[0];
    assign bus_b.wr_data  = s_wd[0];
    assign bus_b.rsv_en   = s_rsv;
    assign bus_b.rsv_addr = s_ra;

    regfile_mp #(.WIDTH(32), .NUM_REGS(24), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    regfile_mp #(.WIDTH(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Architectural state of each configuration.
    logic [31:0] ma_regs [32];
    logic        ma_pend [32];
    logic [31:0] mb_regs [32];
    logic        mb_pend [32];

    // State update: reset clears all; writes land and retire the producer; a reservation
    // in the same cycle leaves the register pending.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                ma_regs[r] <= '0;
                ma_pend[r] <= 1'b0;
                mb_regs[r] <= '0;
                mb_pend[r] <= 1'b0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (s_we[j] && s_wa[j] != 0 && s_wa[j] < 24) begin
                    ma_regs[s_wa[j]] <= s_wd[j];
                    ma_pend[s_wa[j]] <= 1'b0;
                end
            end
            if (s_rsv && s_ra != 0 && s_ra < 24) ma_pend[s_ra] <= 1'b1;
            if (s_we[0] && s_wa[0] != 0) begin
                mb_regs[s_wa[0]] <= s_wd[0];
                mb_pend[s_wa[0]] <= 1'b0;
            end
            if (s_rsv && s_ra != 0) mb_pend[s_ra] <= 1'b1;
        end
    end

    // Expected {pending, data} seen by a read of address ra.
    function automatic logic [32:0] model_rd(input logic [31:0] regs [32], input logic pend [32],
                                             input int nregs, input bit byp,
                                             input logic [1:0] we, input logic [1:0][4:0] wa,
                                             input logic [1:0][31:0] wd, input logic [4:0] ra);
        logic [32:0] r;
        if (ra == 0 || int'(ra) >= nregs) return 33'b0;
        r = {pend[ra], regs[ra]};
        if (byp) begin
            for (int j = 0; j < 2; j++) begin
                if (we[j] && wa[j] == ra) r = {1'b0, wd[j]};
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, mid-period: both DUTs, both read ports, data and pending.
    always @(negedge clk) begin : compare
        logic [32:0] e;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                e = model_rd(ma_regs, ma_pend, 24, 1'b1, s_we, s_wa, s_wd, s_rd[i]);
                check($sformatf("a_rd_data%0d", i), bus_a.rd_data[i], e[31:0]);
                check($sformatf("a_rd_pend%0d", i), 32'(bus_a.rd_pending[i]), 32'(e[32]));
                e = model_rd(mb_regs, mb_pend, 32, 1'b0, s_we & 2'b01, s_wa, s_wd, s_rd[i]);
                check($sformatf("b_rd_data%0d", i), bus_b.rd_data[i], e[31:0]);
                check($sformatf("b_rd_pend%0d", i), 32'(bus_b.rd_pending[i]), 32'(e[32]));
            end
        end
    end

    // Apply one cycle of stimulus just after the rising edge.
    task automatic drive(input logic rst, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1,
                         input logic rsv, input logic [4:0] ra);
        @(posedge clk);
        #1;
        rst_n = rst;
        s_rd  = {r1, r0};
        s_we  = we;
        s_wa  = {a1, a0};
        s_wd  = {d1, d0};
        s_rsv = rsv;
        s_ra  = ra;
        #2;
    endtask

    task automatic idle_rd(input logic [4:0] r0, input logic [4:0] r1);
        drive(1'b1, r0, r1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    initial begin
        drive(1'b0, 5'd5, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        drive(1'b0, 5'd5, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk_en = 1'b1;
        check("rst_a_r5", bus_a.rd_data[0], 32'h0);
        check("rst_b_pend", 32'(bus_b.rd_pending[0]), 32'h0);

        // Reset clears a written register and overrides a simultaneous write/reservation.
        drive(1'b1, 5'd5, 5'd9, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0);
        check("byp_a_r5", bus_a.rd_data[0], 32'hDEADBEEF);
        check("nobyp_b_r5", bus_b.rd_data[0], 32'h0);
        idle_rd(5'd5, 5'd0);
        check("wr_b_r5", bus_b.rd_data[0], 32'hDEADBEEF);
        drive(1'b0, 5'd5, 5'd0, 2'b01, 5'd5, 32'h1111, 5'd0, 32'h0, 1'b1, 5'd5);
        idle_rd(5'd5, 5'd0);
        check("rst2_a_r5", bus_a.rd_data[0], 32'h0);
        check("rst2_a_pend", 32'(bus_a.rd_pending[0]), 32'h0);

        // x0 ignores writes and reservations.
        drive(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b1, 5'd0);
        check("x0_a_same", bus_a.rd_data[0], 32'h0);
        idle_rd(5'd0, 5'd0);
        check("x0_b_data", bus_b.rd_data[1], 32'h0);
        check("x0_a_pend", 32'(bus_a.rd_pending[0]), 32'h0);

        // Bypass on A, old value then new value on B.
        drive(1'b1, 5'd7, 5'd7, 2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b0, 5'd0);
        check("byp_a_r7", bus_a.rd_data[0], 32'hA5A5A5A5);
        check("old_b_r7", bus_b.rd_data[0], 32'h0);
        idle_rd(5'd7, 5'd0);
        check("new_b_r7", bus_b.rd_data[0], 32'hA5A5A5A5);

        // Two ports to r3 on A: port 1 wins, both forwarded and stored.
        drive(1'b1, 5'd3, 5'd0, 2'b11, 5'd3, 32'h11, 5'd3, 32'h22, 1'b0, 5'd0);
        check("conf_a_byp", bus_a.rd_data[0], 32'h22);
        idle_rd(5'd3, 5'd0);
        check("conf_a_r3", bus_a.rd_data[0], 32'h22);
        check("conf_b_r3", bus_b.rd_data[0], 32'h11);

        // Scoreboard on r9.
        drive(1'b1, 5'd9, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9);
        check("rsv_a_before", 32'(bus_a.rd_pending[0]), 32'h0);
        idle_rd(5'd9, 5'd0);
        check("rsv_a_set", 32'(bus_a.rd_pending[0]), 32'h1);
        check("rsv_b_set", 32'(bus_b.rd_pending[0]), 32'h1);
        drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0);
        check("clr_a_same", 32'(bus_a.rd_pending[0]), 32'h0);
        check("clr_b_same", 32'(bus_b.rd_pending[0]), 32'h1);
        idle_rd(5'd9, 5'd0);
        check("clr_b_next", 32'(bus_b.rd_pending[0]), 32'h0);
        check("clr_b_data", bus_b.rd_data[0], 32'h55);
        drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd9, 32'h66, 5'd0, 32'h0, 1'b1, 5'd9);
        idle_rd(5'd9, 5'd0);
        check("both_a_pend", 32'(bus_a.rd_pending[0]), 32'h1);
        check("both_a_data", bus_a.rd_data[0], 32'h66);
        check("both_b_pend", 32'(bus_b.rd_pending[0]), 32'h1);

        // Address 30: unmapped on A (24 regs), ordinary on B.
        drive(1'b1, 5'd30, 5'd30, 2'b01, 5'd30, 32'hCAFE, 5'd0, 32'h0, 1'b1, 5'd30);
        check("rng_a_byp", bus_a.rd_data[0], 32'h0);
        idle_rd(5'd30, 5'd23);
        check("rng_a_data", bus_a.rd_data[0], 32'h0);
        check("rng_a_pend", 32'(bus_a.rd_pending[0]), 32'h0);
        check("rng_b_data", bus_b.rd_data[0], 32'hCAFE);
        check("rng_b_pend", 32'(bus_b.rd_pending[0]), 32'h1);

        // Port 1 alone writes A; B has no second port.
        drive(1'b1, 5'd12, 5'd0, 2'b10, 5'd0, 32'h0, 5'd12, 32'h77, 1'b0, 5'd0);
        idle_rd(5'd12, 5'd23);
        check("p1_a_r12", bus_a.rd_data[0], 32'h77);
        check("p1_b_r12", bus_b.rd_data[0], 32'h0);

        // Sweep: overlapping writes, reservations and reads, checked by the model each cycle.
        for (int k = 1; k <= 22; k++) begin
            drive(1'b1, 5'(k), 5'(k - 1), 2'((k % 3) + 1), 5'(k), 32'(k) * 32'h01010101 ^ 32'h5A,
                  5'(k + 2), 32'(k) << 8, (k % 2) == 0, 5'(k + 1));
        end
        for (int k = 0; k < 26; k += 2) idle_rd(5'(k), 5'(k + 1));

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
